// File: rtl/spi_peripheral_byte_if.sv
// Byte-level SPI responder bundle: SPI pins plus the local transmit/receive handshake.
//   slave  : view used by the responder (pins in, MISO and status out)
//   master : view used by whatever drives the pins and the local handshake
interface spi_peripheral_byte_if;
  logic       spi_cs_n;
  logic       spi_sclk;
  logic       spi_mosi;
  logic       spi_miso;
  logic [7:0] tx_data;
  logic       tx_load;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_underrun;
  logic       busy;

  modport slave (
    input  spi_cs_n, spi_sclk, spi_mosi, tx_data, tx_load,
    output spi_miso, tx_ready, rx_data, rx_valid, tx_underrun, busy
  );

  modport master (
    output spi_cs_n, spi_sclk, spi_mosi, tx_data, tx_load,
    input  spi_miso, tx_ready, rx_data, rx_valid, tx_underrun, busy
  );
endinterface

// File: rtl/spi_peripheral_byte.sv
// SPI mode-0 responder, MSB first, running entirely in the clk domain.
// Oversamples cs_n/sclk/mosi, deserializes MOSI into bytes and serializes a
// one-deep transmit holding register onto MISO.
//   clk, rst_n : system clock, asynchronous active-low reset
//   spi_if     : slave modport -- SPI pins, tx_data/tx_load/tx_ready,
//                rx_data/rx_valid, tx_underrun, busy
module spi_peripheral_byte #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  spi_peripheral_byte_if.slave  spi_if
);

  localparam int unsigned DW = 8;
  localparam int unsigned CW = 3;

  typedef enum logic [0:0] {IDLE, ACTIVE} state_e;

  // Synchronizers and one-cycle-delayed copies for edge detection
  logic [SYNC_STAGES-1:0] cs_sync_q, sclk_sync_q, mosi_sync_q;
  logic                   cs_prev_q, sclk_prev_q;
  logic [SYNC_STAGES:0]   flush_q;
  logic                   armed_q, armed_d;

  state_e          state_q, state_d;
  logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DW-2:0]   rx_sh_q, rx_sh_d;
  logic [DW-1:0]   tx_sh_q, tx_sh_d;
  logic [DW-1:0]   hold_q, hold_d;
  logic            tx_ready_q, tx_ready_d;
  logic [DW-1:0]   rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            underrun_q, underrun_d;
  logic            miso_q, miso_d;
  logic            busy_q, busy_d;
  logic            load_slot;

  logic cs_s, sclk_s, mosi_s;
  logic cs_fall, cs_rise, sclk_rise, sclk_fall;

  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // A cs_n fall only counts once cs_n has been seen high with the pipeline
  // flushed, so a frame already running when reset deasserts is ignored.
  assign cs_fall   = armed_q & cs_prev_q & ~cs_s;
  assign cs_rise   = cs_s & ~cs_prev_q;
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;

  assign armed_d = armed_q | (flush_q[SYNC_STAGES] & cs_prev_q);

  // Input synchronizers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync_q   <= '1;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_prev_q   <= 1'b1;
      sclk_prev_q <= 1'b0;
      flush_q     <= '0;
      armed_q     <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_if.spi_cs_n};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_if.spi_sclk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_if.spi_mosi};
      cs_prev_q   <= cs_s;
      sclk_prev_q <= sclk_s;
      flush_q     <= {flush_q[SYNC_STAGES-1:0], 1'b1};
      armed_q     <= armed_d;
    end
  end

  // State, shifters, holding register and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      rx_sh_q    <= '0;
      tx_sh_q    <= '0;
      hold_q     <= '0;
      tx_ready_q <= 1'b1;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      underrun_q <= 1'b0;
      miso_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_sh_q    <= rx_sh_d;
      tx_sh_q    <= tx_sh_d;
      hold_q     <= hold_d;
      tx_ready_q <= tx_ready_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      underrun_q <= underrun_d;
      miso_q     <= miso_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state, datapath and outputs
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_sh_d    = rx_sh_q;
    tx_sh_d    = tx_sh_q;
    hold_d     = hold_q;
    tx_ready_d = tx_ready_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    underrun_d = 1'b0;
    load_slot  = 1'b0;

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d   = ACTIVE;
          bit_cnt_d = '0;
          load_slot = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          // Abort at any bit: partial byte and pending shifter are dropped
          state_d   = IDLE;
          bit_cnt_d = '0;
          rx_sh_d   = '0;
          tx_sh_d   = '0;
        end else if (sclk_rise) begin
          rx_sh_d = {rx_sh_q[DW-3:0], mosi_s};
          if (bit_cnt_q == CW'(DW - 1)) begin
            rx_data_d  = {rx_sh_q, mosi_s};
            rx_valid_d = 1'b1;
            bit_cnt_d  = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end else if (sclk_fall) begin
          if (bit_cnt_q != '0) tx_sh_d = {tx_sh_q[DW-2:0], 1'b0};
          else                 load_slot = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Byte slot start: move holding register into the shifter, or underrun
    if (load_slot) begin
      if (!tx_ready_q) begin
        tx_sh_d    = hold_q;
        tx_ready_d = 1'b1;
      end else begin
        tx_sh_d    = '0;
        underrun_d = 1'b1;
      end
    end

    // A slot transfer needs tx_ready_q=0, so it never collides with an accepted load
    if (spi_if.tx_load && tx_ready_q) begin
      hold_d     = spi_if.tx_data;
      tx_ready_d = 1'b0;
    end

    miso_d = (state_d == ACTIVE) ? tx_sh_d[DW-1] : 1'b0;
    busy_d = (state_d == ACTIVE);
  end

  assign spi_if.spi_miso    = miso_q;
  assign spi_if.tx_ready    = tx_ready_q;
  assign spi_if.rx_data     = rx_data_q;
  assign spi_if.rx_valid    = rx_valid_q;
  assign spi_if.tx_underrun = underrun_q;
  assign spi_if.busy        = busy_q;

endmodule

// File: tb/tb_spi_peripheral_byte.sv
// Self-checking bench for spi_peripheral_byte: a mode-0 SPI master at clk/8,
// a transmit model (holding register + slot starts) and an rx scoreboard.
module tb_spi_peripheral_byte;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_peripheral_byte_if bus_if();

  spi_peripheral_byte #(.SYNC_STAGES(2)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .spi_if (bus_if)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] rx_q[$];   // bytes the master sent, awaiting rx_valid
  logic [7:0] tx_q[$];   // model of the holding register contents
  logic [7:0] exp_sh;    // byte the current slot should shift out
  bit         m_ready;   // model tx_ready
  int         exp_ur;    // model underrun count for the current test
  int         ur_cnt, rxv_cnt, rx_spurious, rxv_wide, ur_at_last_rise;
  logic       rxv_prev;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // Output monitor: counts pulses and retires rx scoreboard entries
  initial begin
    ur_cnt = 0; rxv_cnt = 0; rx_spurious = 0; rxv_wide = 0; rxv_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus_if.tx_underrun) ur_cnt++;
        if (bus_if.rx_valid) begin
          rxv_cnt++;
          if (rxv_prev) rxv_wide++;
          if (rx_q.size() > 0) check("rx_data", bus_if.rx_data, rx_q.pop_front());
          else                 rx_spurious++;
        end
        rxv_prev = bus_if.rx_valid;
      end else begin
        rxv_prev = 1'b0;
      end
    end
  end

  initial begin
    #500us;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [7:0] b);
    tick(1);
    bus_if.tx_data = b;
    bus_if.tx_load = 1'b1;
    if (m_ready) begin
      tx_q.push_back(b);
      m_ready = 1'b0;
    end
    tick(1);
    bus_if.tx_load = 1'b0;
  endtask

  // Model of a byte-slot start (frame start or trailing sclk fall)
  task automatic slot_start();
    if (tx_q.size() > 0) exp_sh = tx_q.pop_front();
    else begin
      exp_sh = 8'h00;
      exp_ur++;
    end
    m_ready = 1'b1;
  endtask

  task automatic cs_low();
    tick(1);
    bus_if.spi_cs_n = 1'b0;
    slot_start();
    tick(6);
  endtask

  task automatic cs_high();
    tick(4);
    bus_if.spi_cs_n = 1'b1;
    tick(10);
  endtask

  task automatic send_bits(input logic [7:0] b, input int nbits, output logic [7:0] rd);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      bus_if.spi_mosi = b[i];
      tick(4);
      r[i] = bus_if.spi_miso;
      bus_if.spi_sclk = 1'b1;
      tick(4);
      if (i == 0) ur_at_last_rise = ur_cnt;
      bus_if.spi_sclk = 1'b0;
    end
    rd = r;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [7:0] rd;
    rx_q.push_back(b);
    send_bits(b, 8, rd);
    check("miso_byte", rd, exp_sh);
    slot_start();  // the trailing sclk fall opens the next slot
  endtask

  task automatic wait_ready();
    for (int k = 0; k < 50 && !bus_if.tx_ready; k++) tick(1);
    check("wait_tx_ready", 8'(bus_if.tx_ready), 8'h01);
  endtask

  int ur0, rx0;
  logic [7:0] dummy;

  initial begin
    bus_if.spi_cs_n = 1'b1;
    bus_if.spi_sclk = 1'b0;
    bus_if.spi_mosi = 1'b0;
    bus_if.tx_data  = 8'h00;
    bus_if.tx_load  = 1'b0;
    tx_q.delete();
    m_ready = 1'b1;
    exp_sh = 8'h00;
    exp_ur = 0;
    ur_at_last_rise = 0;

    // Reset with pins toggling, cs_n low by the end
    for (int i = 0; i < 8; i++) begin
      tick(1);
      bus_if.spi_sclk = ~bus_if.spi_sclk;
      bus_if.spi_mosi = i[1];
      if (i == 5) bus_if.spi_cs_n = 1'b0;
    end
    check("rst_miso",     8'(bus_if.spi_miso),    8'h00);
    check("rst_tx_ready", 8'(bus_if.tx_ready),    8'h01);
    check("rst_rx_data",  bus_if.rx_data,         8'h00);
    check("rst_rx_valid", 8'(bus_if.rx_valid),    8'h00);
    check("rst_underrun", 8'(bus_if.tx_underrun), 8'h00);
    check("rst_busy",     8'(bus_if.busy),        8'h00);

    // Frame in progress at reset release must be ignored
    tick(1);
    bus_if.spi_sclk = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(4); bus_if.spi_sclk = 1'b1;
      tick(4); bus_if.spi_sclk = 1'b0;
    end
    tick(4);
    check("postrst_busy",  8'(bus_if.busy), 8'h00);
    check("postrst_rxv",   8'(rxv_cnt),     8'h00);
    check("postrst_ur",    8'(ur_cnt),      8'h00);
    bus_if.spi_cs_n = 1'b1;
    tick(10);

    // Single byte
    ur0 = ur_cnt; rx0 = rxv_cnt; exp_ur = 0;
    load(8'hA5);
    cs_low();
    check("single_tx_ready", 8'(bus_if.tx_ready), 8'(m_ready));
    check("single_busy",     8'(bus_if.busy),     8'h01);
    send_byte(8'h3C);
    cs_high();
    check("single_rxv_cnt", 8'(rxv_cnt - rx0), 8'h01);
    check("single_ur",      8'(ur_cnt - ur0),  8'(exp_ur));
    check("single_idle_busy", 8'(bus_if.busy), 8'h00);
    check("single_idle_miso", 8'(bus_if.spi_miso), 8'h00);

    // Back-to-back
    ur0 = ur_cnt; rx0 = rxv_cnt; exp_ur = 0;
    load(8'h55);
    cs_low();
    wait_ready();
    load(8'hAA);
    send_byte(8'h01);
    send_byte(8'h80);
    check("b2b_ur_in_frame", 8'(ur_at_last_rise - ur0), 8'h00);
    cs_high();
    check("b2b_rxv_cnt", 8'(rxv_cnt - rx0), 8'h02);
    check("b2b_ur",      8'(ur_cnt - ur0),  8'(exp_ur));

    // Underrun
    ur0 = ur_cnt; rx0 = rxv_cnt; exp_ur = 0;
    cs_low();
    send_byte(8'hF0);
    check("ur_in_frame", 8'(ur_at_last_rise - ur0), 8'h01);
    cs_high();
    check("ur_total",   8'(ur_cnt - ur0),  8'(exp_ur));
    check("ur_rx_data", bus_if.rx_data,    8'hF0);
    check("ur_rxv_cnt", 8'(rxv_cnt - rx0), 8'h01);

    // Abort after 5 bits, then a clean frame
    ur0 = ur_cnt; rx0 = rxv_cnt; exp_ur = 0;
    cs_low();
    send_bits(8'hE7, 5, dummy);
    cs_high();
    check("abort_rxv",     8'(rxv_cnt - rx0),     8'h00);
    check("abort_bit_cnt", 8'(dut.bit_cnt_q),     8'h00);
    check("abort_busy",    8'(bus_if.busy),       8'h00);
    check("abort_partial", 8'(dummy[7:3]),        8'h00);
    cs_low();
    send_byte(8'hC3);
    cs_high();
    check("abort_next_rx", bus_if.rx_data,   8'hC3);
    check("abort_ur",      8'(ur_cnt - ur0), 8'(exp_ur));

    // Second load while not ready is ignored
    ur0 = ur_cnt; exp_ur = 0;
    load(8'h11);
    load(8'h22);
    check("ign_tx_ready", 8'(bus_if.tx_ready), 8'(m_ready));
    cs_low();
    send_byte(8'h5A);
    check("ign_miso_exp", exp_sh, 8'h00);
    cs_high();
    check("ign_ur", 8'(ur_cnt - ur0), 8'(exp_ur));

    check("rx_pending",  8'(rx_q.size()), 8'h00);
    check("rx_spurious", 8'(rx_spurious), 8'h00);
    check("rxv_width",   8'(rxv_wide),    8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
